// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] EXTEND_CODE = 8'hE0;
    localparam int         FRAME_BITS  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronisers for the PS/2 lines, a level filter on the clock line,
// and a registered one-cycle pulse on each filtered falling edge.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_f;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_f     <= 1'b1;
            fcnt      <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            fall      <= 1'b0;
            // Any sample matching the current level restarts the run of disagreeing samples.
            if (clk_sync[1] == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                clk_f <= clk_sync[1];
                fcnt  <= '0;
                fall  <= clk_f;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign data_s = data_sync[1];
endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: checks start/parity/stop, aborts stalled
// frames, and holds valid high for a fixed window after each good byte.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int VALID_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] code,
    output logic       valid,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int HW = $clog2(VALID_HOLD);

    logic          data_s;
    logic          fall;
    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic [HW-1:0] hold;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2Clk),
        .ps2_data(ps2Data),
        .data_s  (data_s),
        .fall    (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            par_ok <= 1'b0;
            tcnt   <= '0;
            hold   <= '0;
            code   <= 8'h00;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;

            if (valid) begin
                if (hold == '0) valid <= 1'b0;
                else            hold  <= hold - 1'b1;
            end

            // A fall in the same cycle as expiry wins: the frame is still alive.
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                tcnt  <= '0;
                err   <= 1'b1;
                state <= IDLE;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_s, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, data_s};
                        state  <= STOP;
                    end
                    STOP: begin
                        if (data_s && par_ok) begin
                            code  <= shreg;
                            valid <= 1'b1;
                            hold  <= HW'(VALID_HOLD - 1);
                        end else begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench: stimulus queues expected bytes/errors, a monitor pops them
// as the receiver raises valid or err. Bit period and timeout are scaled down.
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int TO   = 500;
    localparam int HALF = 20;
    localparam int HOLD = 4;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       valid;
    logic       err;

    exp_t       q[$];
    exp_t       e;
    int         checks = 0;
    int         fails = 0;
    bit         prev_v = 1'b0;
    bit         prev_e = 1'b0;
    int         vcnt = 0;
    logic [7:0] last_code = 8'h00;

    always #5 clk = ~clk;

    ps2_receiver #(.FILTER_LEN(8), .TIMEOUT(TO), .VALID_HOLD(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .ps2Clk (ps2_clk),
        .ps2Data(ps2_data),
        .code   (code),
        .valid  (valid),
        .err    (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits are driven LSB first; data changes while the clock is high.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF / 2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit p, input bit s, input bit good);
        exp_t x;
        x.is_err = !good;
        x.code   = d;
        q.push_back(x);
        send_bits({s, p, d, 1'b0}, FRAME_BITS);
        repeat (30) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v    = 1'b0;
            prev_e    = 1'b0;
            vcnt      = 0;
            last_code = 8'h00;
        end else begin
            if (valid && err) check("valid_err_overlap", 32'(1), 32'(0));
            if (valid && !prev_v) begin
                vcnt = 1;
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'(code), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("event_kind_valid", 32'(0), 32'(e.is_err));
                    check("code", 32'(code), 32'(e.code));
                    last_code = e.code;
                end
            end else if (valid) begin
                vcnt++;
            end
            if (!valid && prev_v) check("valid_width", 32'(vcnt), 32'(HOLD));
            if (err) begin
                if (prev_e) check("err_width", 32'(2), 32'(1));
                if (q.size() == 0) begin
                    check("unexpected_err", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("event_kind_err", 32'(1), 32'(e.is_err));
                    check("code_kept_on_err", 32'(code), 32'(last_code));
                end
            end
            prev_v = valid;
            prev_e = err;
        end
    end

    initial begin
        exp_t x;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_code", 32'(code), 32'(0));
        check("reset_valid", 32'(valid), 32'(0));
        check("reset_err", 32'(err), 32'(0));

        // Good frame, then a break/make pair.
        send_frame(8'h1D, 1'b1, 1'b1, 1'b1);
        send_frame(BREAK_CODE, 1'b1, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1, 1'b1);

        // Bad parity, bad stop, then a good retry.
        send_frame(8'h44, 1'b0, 1'b1, 1'b0);
        send_frame(8'h4B, 1'b1, 1'b0, 1'b0);
        send_frame(8'h4B, 1'b1, 1'b1, 1'b1);

        // Stall after start + 5 data bits: exactly one timeout error.
        x.is_err = 1'b1;
        x.code   = 8'h00;
        q.push_back(x);
        send_bits({1'b1, 1'b1, 8'h1B, 1'b0}, 6);
        repeat (TO + 100) @(posedge clk);
        check("timeout_drained", 32'(q.size()), 32'(0));
        send_frame(8'h1B, 1'b1, 1'b1, 1'b1);

        // Short glitch on the clock line must be filtered out.
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_no_event", 32'(q.size()), 32'(0));

        // Reset in the middle of a frame, then a clean frame.
        send_bits({1'b1, 1'b1, 8'h1D, 1'b0}, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_code", 32'(code), 32'(0));
        check("midrst_valid", 32'(valid), 32'(0));
        send_frame(8'h1D, 1'b1, 1'b1, 1'b1);

        repeat (20) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'(0));
        check("final_valid", 32'(valid), 32'(0));
        check("final_code", 32'(code), 32'h1D);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
